proposal_commit: RTL and testbench

//  Consumer end of the Propose interface. Takes one proposed value per handshake for the chosen integer variable.

---
 rtl/proposal_commit_pkg.sv | 40 ++++
 rtl/proposal_commit_lfsr16_galois.sv | 40 ++++
 rtl/proposal_commit.sv | 179 +++++++++++++++++
 tb/tb_proposal_commit.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proposal_commit_pkg.sv
// ---------------------------------------------------------------------------
// proposal_commit_pkg
//   Shared constants, FSM state encoding and LFSR helper functions for the
//   proposal commit stage and anything else that needs the same LFSR.
//   Contents:
//     DEF_*            default sizes for the integer-variable store
//     LFSR_RESET_SEED  value the LFSR takes at reset and replaces a 0 seed
//     LFSR_TAPS        Galois feedback mask (shift right, XOR when LSB=1)
//     ACCEPT_ALWAYS    threshold that bypasses the random comparison
//     state_t          IDLE / DECIDE / WRITE
//     lfsr_next()      one Galois step
//     seed_fix()       maps the forbidden all-zero seed to LFSR_RESET_SEED
// ---------------------------------------------------------------------------
package proposal_commit_pkg;

   localparam int DEF_N_VARS = 4;
   localparam int DEF_VAR_W  = 8;
   localparam int DEF_IDX_W  = 3;
   localparam int DEF_CNT_W  = 16;

   localparam logic [15:0] LFSR_RESET_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS       = 16'hB400;
   localparam logic [15:0] ACCEPT_ALWAYS   = 16'hFFFF;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DECIDE = 2'd1,
      ST_WRITE  = 2'd2
   } state_t;

   function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
      return cur[0] ? ((cur >> 1) ^ LFSR_TAPS) : (cur >> 1);
   endfunction

   // An all-zero Galois LFSR is stuck forever, so zero is never loaded.
   function automatic logic [15:0] seed_fix(input logic [15:0] s);
      return (s == 16'h0000) ? LFSR_RESET_SEED : s;
   endfunction

endpackage

// File: rtl/proposal_commit_lfsr16_galois.sv
// ---------------------------------------------------------------------------
// lfsr16_galois
//   16-bit Galois LFSR (shift right, XOR LFSR_TAPS when the LSB is 1).
//   Ports:
//     clk, rst_n  clock, asynchronous active-low reset (value -> LFSR_RESET_SEED)
//     load        replace the state with seed (zero seed -> LFSR_RESET_SEED)
//     seed        seed value
//     step        advance one step; when load is also set the step is taken
//                 from the freshly loaded seed, not from the old state
//     value       current register value
// ---------------------------------------------------------------------------
module lfsr16_galois
   import proposal_commit_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic [15:0] seed,
   input  logic        step,
   output logic [15:0] value
);

   logic [15:0] state_q;
   logic [15:0] base;

   always_comb begin
      base = load ? seed_fix(seed) : state_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= LFSR_RESET_SEED;
      end else if (load || step) begin
         state_q <= step ? lfsr_next(base) : base;
      end
   end

   assign value = state_q;

endmodule

// File: rtl/proposal_commit.sv
// ---------------------------------------------------------------------------
// proposal_commit
//   Consumer end of the Propose interface. Accepts one proposal (variable
//   index + new value + accept threshold) per handshake, makes a Metropolis
//   accept/reject decision against a 16-bit LFSR sample and, on accept,
//   writes the value into the packed current-assignment register.
//
//   Handshake: a proposal transfers on a rising edge where in_proposal_valid
//   and out_proposal_ready are both 1. out_proposal_ready is registered and
//   is only high in IDLE; valid may be held or dropped freely while ready=0.
//
//   Timing: handshake edge T -> DECIDE cycle -> WRITE cycle (commit pulse,
//   written value and updated counters all visible) -> IDLE, ready again.
//
//   Ports:
//     in_clock, in_reset_n      clock, asynchronous active-low reset
//     in_init_valid/_assignment load the whole assignment (IDLE only)
//     in_seed_load/in_seed      load the LFSR (IDLE only)
//     in_proposal_valid/out_proposal_ready, in_choosen_index,
//     in_proposed_assignment, in_accept_threshold   proposal channel
//     out_current_assignment    registered packed assignment
//     out_commit_valid          one-cycle decision pulse
//     out_commit_accepted       decision, qualified by out_commit_valid
//     out_index_error           index >= N_VARS, qualified by commit_valid
//     out_accept_count/out_reject_count  saturating statistics
//     out_state                 FSM state for debug/observation
// ---------------------------------------------------------------------------
module proposal_commit
   import proposal_commit_pkg::*;
#(
   parameter int N_VARS = DEF_N_VARS,
   parameter int VAR_W  = DEF_VAR_W,
   parameter int IDX_W  = DEF_IDX_W,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic                    in_clock,
   input  logic                    in_reset_n,
   input  logic                    in_init_valid,
   input  logic [N_VARS*VAR_W-1:0] in_init_assignment,
   input  logic                    in_seed_load,
   input  logic [15:0]             in_seed,
   input  logic                    in_proposal_valid,
   output logic                    out_proposal_ready,
   input  logic [IDX_W-1:0]        in_choosen_index,
   input  logic [VAR_W-1:0]        in_proposed_assignment,
   input  logic [15:0]             in_accept_threshold,
   output logic [N_VARS*VAR_W-1:0] out_current_assignment,
   output logic                    out_commit_valid,
   output logic                    out_commit_accepted,
   output logic                    out_index_error,
   output logic [CNT_W-1:0]        out_accept_count,
   output logic [CNT_W-1:0]        out_reject_count,
   output logic [1:0]              out_state
);

   localparam logic [31:0] N_VARS_U = 32'(N_VARS);

   state_t             state_q;
   logic               ready_q;
   logic [IDX_W-1:0]   cap_index;
   logic [VAR_W-1:0]   cap_value;
   logic [15:0]        cap_thr;
   logic               commit_valid_q;
   logic               accepted_q;
   logic               index_error_q;
   logic [CNT_W-1:0]   accept_q;
   logic [CNT_W-1:0]   reject_q;
   logic [VAR_W-1:0]   vars_q [N_VARS];

   logic               handshake;
   logic               idle_seed_load;
   logic               idx_ok;
   logic               decide_accept;
   logic [15:0]        lfsr_value;

   // The LFSR is stepped on the handshake edge, so in DECIDE it already
   // holds the sample that belongs to the captured proposal.
   always_comb begin
      handshake      = (state_q == ST_IDLE) && ready_q && in_proposal_valid;
      idle_seed_load = (state_q == ST_IDLE) && in_seed_load;
      idx_ok         = (32'(cap_index) < N_VARS_U);
      decide_accept  = idx_ok &&
                       ((cap_thr == ACCEPT_ALWAYS) || (lfsr_value < cap_thr));
   end

   lfsr16_galois u_lfsr (
      .clk   (in_clock),
      .rst_n (in_reset_n),
      .load  (idle_seed_load),
      .seed  (in_seed),
      .step  (handshake),
      .value (lfsr_value)
   );

   always_ff @(posedge in_clock or negedge in_reset_n) begin
      if (!in_reset_n) begin
         state_q        <= ST_IDLE;
         ready_q        <= 1'b0;
         cap_index      <= '0;
         cap_value      <= '0;
         cap_thr        <= '0;
         commit_valid_q <= 1'b0;
         accepted_q     <= 1'b0;
         index_error_q  <= 1'b0;
         accept_q       <= '0;
         reject_q       <= '0;
         for (int k = 0; k < N_VARS; k++) begin
            vars_q[k] <= '0;
         end
      end else begin
         commit_valid_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               ready_q <= 1'b1;
               if (in_init_valid) begin
                  for (int k = 0; k < N_VARS; k++) begin
                     vars_q[k] <= in_init_assignment[k*VAR_W +: VAR_W];
                  end
               end
               if (handshake) begin
                  cap_index <= in_choosen_index;
                  cap_value <= in_proposed_assignment;
                  cap_thr   <= in_accept_threshold;
                  ready_q   <= 1'b0;
                  state_q   <= ST_DECIDE;
               end
            end

            // Decision, write and counter update share one edge so the
            // WRITE cycle shows the pulse and its effects together.
            ST_DECIDE: begin
               ready_q        <= 1'b0;
               commit_valid_q <= 1'b1;
               accepted_q     <= decide_accept;
               index_error_q  <= !idx_ok;
               if (decide_accept) begin
                  for (int k = 0; k < N_VARS; k++) begin
                     if (cap_index == IDX_W'(k)) begin
                        vars_q[k] <= cap_value;
                     end
                  end
                  if (accept_q != '1) begin
                     accept_q <= accept_q + CNT_W'(1);
                  end
               end else begin
                  if (reject_q != '1) begin
                     reject_q <= reject_q + CNT_W'(1);
                  end
               end
               state_q <= ST_WRITE;
            end

            // Raise ready early so it is already high in the IDLE cycle.
            ST_WRITE: begin
               ready_q <= 1'b1;
               state_q <= ST_IDLE;
            end

            default: begin
               ready_q <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   for (genvar g = 0; g < N_VARS; g++) begin : g_pack
      assign out_current_assignment[g*VAR_W +: VAR_W] = vars_q[g];
   end

   assign out_proposal_ready  = ready_q;
   assign out_commit_valid    = commit_valid_q;
   assign out_commit_accepted = accepted_q;
   assign out_index_error     = index_error_q;
   assign out_accept_count    = accept_q;
   assign out_reject_count    = reject_q;
   assign out_state           = state_q;

endmodule

// File: tb/tb_proposal_commit.sv
// ---------------------------------------------------------------------------
// tb_proposal_commit
//   Directed bench for proposal_commit with N_VARS=4, VAR_W=8, IDX_W=3 and
//   8-bit counters so counter saturation is reachable in a short run.
// ---------------------------------------------------------------------------
module tb_proposal_commit;

   localparam int N_VARS = 4;
   localparam int VAR_W  = 8;
   localparam int IDX_W  = 3;
   localparam int CNT_W  = 8;

   logic                    clk;
   logic                    rst_n;
   logic                    init_valid;
   logic [N_VARS*VAR_W-1:0] init_asg;
   logic                    seed_load;
   logic [15:0]             seed;
   logic                    prop_valid;
   logic                    prop_ready;
   logic [IDX_W-1:0]        prop_idx;
   logic [VAR_W-1:0]        prop_val;
   logic [15:0]             prop_thr;
   logic [N_VARS*VAR_W-1:0] cur_asg;
   logic                    commit_valid;
   logic                    commit_acc;
   logic                    index_err;
   logic [CNT_W-1:0]        acc_cnt;
   logic [CNT_W-1:0]        rej_cnt;
   logic [1:0]              dut_state;

   int checks   = 0;
   int failures = 0;

   // reference model
   logic [15:0]      m_lfsr;
   logic [VAR_W-1:0] m_vars [N_VARS];
   logic [CNT_W-1:0] m_acc;
   logic [CNT_W-1:0] m_rej;

   proposal_commit #(
      .N_VARS(N_VARS), .VAR_W(VAR_W), .IDX_W(IDX_W), .CNT_W(CNT_W)
   ) dut (
      .in_clock               (clk),
      .in_reset_n             (rst_n),
      .in_init_valid          (init_valid),
      .in_init_assignment     (init_asg),
      .in_seed_load           (seed_load),
      .in_seed                (seed),
      .in_proposal_valid      (prop_valid),
      .out_proposal_ready     (prop_ready),
      .in_choosen_index       (prop_idx),
      .in_proposed_assignment (prop_val),
      .in_accept_threshold    (prop_thr),
      .out_current_assignment (cur_asg),
      .out_commit_valid       (commit_valid),
      .out_commit_accepted    (commit_acc),
      .out_index_error        (index_err),
      .out_accept_count       (acc_cnt),
      .out_reject_count       (rej_cnt),
      .out_state              (dut_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- model helpers ----------------
   function automatic logic [15:0] m_step(input logic [15:0] v);
      return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
   endfunction

   function automatic logic [N_VARS*VAR_W-1:0] m_pack();
      logic [N_VARS*VAR_W-1:0] p;
      for (int k = 0; k < N_VARS; k++) p[k*VAR_W +: VAR_W] = m_vars[k];
      return p;
   endfunction

   task automatic m_reset();
      m_lfsr = 16'hACE1;
      m_acc  = '0;
      m_rej  = '0;
      for (int k = 0; k < N_VARS; k++) m_vars[k] = '0;
   endtask

   // Expected outcome of a proposal given the model LFSR sample already stepped.
   task automatic m_commit(input logic [IDX_W-1:0] idx, input logic [VAR_W-1:0] val,
                           input logic [15:0] thr, output bit e_acc, output bit e_err);
      e_err = (int'(idx) >= N_VARS);
      e_acc = !e_err && (thr == 16'hFFFF || m_lfsr < thr);
      if (e_acc) begin
         m_vars[idx] = val;
         if (m_acc != '1) m_acc = m_acc + 1'b1;
      end else begin
         if (m_rej != '1) m_rej = m_rej + 1'b1;
      end
   endtask

   // ---------------- driver ----------------
   // Performs one handshake and observes the cycles after it:
   // early = commit_valid one cycle after handshake (must be 0),
   // pulse = commit_valid two cycles after (must be 1), late = three after (0).
   task automatic do_propose(
      input  logic [IDX_W-1:0] idx, input logic [VAR_W-1:0] val, input logic [15:0] thr,
      input  bit with_seed, input logic [15:0] sd, input bit hold_ctrl,
      output bit to, output bit early, output bit pulse, output bit late,
      output bit acc, output bit err, output logic [N_VARS*VAR_W-1:0] asg,
      output logic [CNT_W-1:0] ac, output logic [CNT_W-1:0] rc);
      int n;
      to = 0; early = 0; pulse = 0; late = 0; acc = 0; err = 0; asg = '0; ac = '0; rc = '0;
      n = 0;
      @(negedge clk);
      while (!prop_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!prop_ready) begin
         to = 1;
         return;
      end
      prop_valid = 1'b1;
      prop_idx   = idx;
      prop_val   = val;
      prop_thr   = thr;
      if (with_seed) begin
         seed_load = 1'b1;
         seed      = sd;
      end
      @(posedge clk);
      if (with_seed) m_lfsr = (sd == 16'h0) ? 16'hACE1 : sd;
      m_lfsr = m_step(m_lfsr);
      #1;
      prop_valid = 1'b0;
      seed_load  = 1'b0;
      if (hold_ctrl) begin
         init_valid = 1'b1;
         init_asg   = {N_VARS{8'hAA}};
         seed_load  = 1'b1;
         seed       = 16'h0001;
      end
      early = commit_valid;
      @(posedge clk);
      #1;
      pulse = commit_valid;
      acc   = commit_acc;
      err   = index_err;
      asg   = cur_asg;
      ac    = acc_cnt;
      rc    = rej_cnt;
      @(posedge clk);
      #1;
      late       = commit_valid;
      init_valid = 1'b0;
      seed_load  = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      int pulses;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (prop_ready !== 1'b0) begin
         failures++; $display("FAIL reset_ready_in_reset: got %b expected 0", prop_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      m_reset();
      pulses = 0;
      repeat (5) begin
         @(posedge clk); #1;
         if (commit_valid) pulses++;
      end
      checks++;
      if (prop_ready !== 1'b1) begin
         failures++; $display("FAIL reset_ready: got %b expected 1", prop_ready);
      end
      checks++;
      if (cur_asg !== 32'h0) begin
         failures++; $display("FAIL reset_assignment: got %h expected 00000000", cur_asg);
      end
      checks++;
      if (acc_cnt !== 8'h0 || rej_cnt !== 8'h0) begin
         failures++; $display("FAIL reset_counts: got acc=%h rej=%h expected 00/00", acc_cnt, rej_cnt);
      end
      checks++;
      if (pulses != 0 || dut_state !== 2'd0) begin
         failures++; $display("FAIL reset_idle: got pulses=%0d state=%0d expected 0/0", pulses, dut_state);
      end
   endtask

   task automatic test_init_accept();
      bit to, e, p, l, a, r, ea, er;
      logic [31:0] asg;
      logic [7:0] ac, rc;
      @(negedge clk);
      init_valid = 1'b1;
      init_asg   = {8'h04, 8'hFE, 8'h07, 8'h03};
      for (int k = 0; k < N_VARS; k++) m_vars[k] = init_asg[k*8 +: 8];
      @(negedge clk);
      init_valid = 1'b0;
      checks++;
      if (cur_asg !== 32'h04FE0703) begin
         failures++; $display("FAIL init_load: got %h expected 04FE0703", cur_asg);
      end
      do_propose(3'd1, 8'd5, 16'hFFFF, 0, 16'h0, 0, to, e, p, l, a, r, asg, ac, rc);
      m_commit(3'd1, 8'd5, 16'hFFFF, ea, er);
      checks++;
      if (to || e || !p || l) begin
         failures++; $display("FAIL accept_pulse_timing: got to=%b T+1=%b T+2=%b T+3=%b expected 0/0/1/0", to, e, p, l);
      end
      checks++;
      if (a !== 1'b1 || r !== 1'b0) begin
         failures++; $display("FAIL accept_flags: got acc=%b err=%b expected 1/0", a, r);
      end
      checks++;
      if (asg !== 32'h04FE0503) begin
         failures++; $display("FAIL accept_write: got %h expected 04FE0503", asg);
      end
      checks++;
      if (ac !== 8'd1 || rc !== 8'd0) begin
         failures++; $display("FAIL accept_counts: got acc=%0d rej=%0d expected 1/0", ac, rc);
      end
   endtask

   task automatic test_reject_thr0();
      bit to, e, p, l, a, r, ea, er;
      logic [31:0] asg;
      logic [7:0] ac, rc;
      do_propose(3'd0, 8'd9, 16'h0000, 0, 16'h0, 0, to, e, p, l, a, r, asg, ac, rc);
      m_commit(3'd0, 8'd9, 16'h0000, ea, er);
      checks++;
      if (to || !p || a !== 1'b0 || r !== 1'b0) begin
         failures++; $display("FAIL thr0_reject: got to=%b pulse=%b acc=%b err=%b expected 0/1/0/0", to, p, a, r);
      end
      checks++;
      if (asg !== 32'h04FE0503 || ac !== 8'd1 || rc !== 8'd1) begin
         failures++; $display("FAIL thr0_state: got asg=%h acc=%0d rej=%0d expected 04FE0503/1/1", asg, ac, rc);
      end
   endtask

   task automatic test_seed();
      bit to, e, p, l, a, r, ea, er;
      logic [31:0] asg;
      logic [7:0] ac, rc;
      // Seed 1 loaded on its own: first step gives B400, not below 8000.
      @(negedge clk);
      seed_load = 1'b1;
      seed      = 16'h0001;
      @(negedge clk);
      seed_load = 1'b0;
      m_lfsr    = 16'h0001;
      do_propose(3'd2, 8'h55, 16'h8000, 0, 16'h0, 0, to, e, p, l, a, r, asg, ac, rc);
      m_commit(3'd2, 8'h55, 16'h8000, ea, er);
      checks++;
      if (to || !p || a !== 1'b0 || asg !== 32'h04FE0503 || rc !== 8'd2) begin
         failures++; $display("FAIL seed1_reject: got acc=%b asg=%h rej=%0d expected 0/04FE0503/2", a, asg, rc);
      end
      // Zero seed with a proposal in the same cycle: ACE1 steps to E270.
      do_propose(3'd2, 8'h66, 16'hE271, 1, 16'h0000, 0, to, e, p, l, a, r, asg, ac, rc);
      m_commit(3'd2, 8'h66, 16'hE271, ea, er);
      checks++;
      if (to || !p || a !== 1'b1 || asg !== 32'h04660503 || ac !== 8'd2) begin
         failures++; $display("FAIL seed0_same_cycle_accept: got acc=%b asg=%h accs=%0d expected 1/04660503/2", a, asg, ac);
      end
      do_propose(3'd3, 8'h77, 16'hE270, 1, 16'h0000, 0, to, e, p, l, a, r, asg, ac, rc);
      m_commit(3'd3, 8'h77, 16'hE270, ea, er);
      checks++;
      if (to || !p || a !== 1'b0 || asg !== 32'h04660503 || rc !== 8'd3) begin
         failures++; $display("FAIL thr_equal_reject: got acc=%b asg=%h rej=%0d expected 0/04660503/3", a, asg, rc);
      end
   endtask

   task automatic test_index_error();
      bit to, e, p, l, a, r, ea, er;
      logic [31:0] asg;
      logic [7:0] ac, rc;
      for (int i = 0; i < 2; i++) begin
         logic [2:0] bad;
         bad = (i == 0) ? 3'd4 : 3'd7;
         do_propose(bad, 8'h99, 16'hFFFF, 0, 16'h0, 0, to, e, p, l, a, r, asg, ac, rc);
         m_commit(bad, 8'h99, 16'hFFFF, ea, er);
         checks++;
         if (to || !p || r !== 1'b1 || a !== 1'b0) begin
            failures++; $display("FAIL index_error_flags idx=%0d: got err=%b acc=%b expected 1/0", bad, r, a);
         end
         checks++;
         if (asg !== 32'h04660503 || rc !== m_rej || ac !== m_acc) begin
            failures++; $display("FAIL index_error_state idx=%0d: got asg=%h rej=%0d acc=%0d expected 04660503/%0d/%0d",
                                 bad, asg, rc, ac, m_rej, m_acc);
         end
      end
   endtask

   task automatic test_lfsr_run();
      bit to, e, p, l, a, r, ea, er;
      logic [31:0] asg;
      logic [7:0] ac, rc;
      int bad;
      bad = 0;
      for (int i = 0; i < 200; i++) begin
         logic [2:0]  idx;
         logic [15:0] thr;
         idx = 3'(i % 5);
         thr = 16'(i * 331 + 32'h1234);
         do_propose(idx, 8'(i), thr, 0, 16'h0, 0, to, e, p, l, a, r, asg, ac, rc);
         m_commit(idx, 8'(i), thr, ea, er);
         checks++;
         if (to || !p || a !== ea || r !== er) begin
            failures++;
            if (bad < 5) $display("FAIL lfsr_run_decision #%0d: got acc=%b err=%b pulse=%b expected %b/%b/1", i, a, r, p, ea, er);
            bad++;
         end
      end
      checks++;
      if (cur_asg !== m_pack() || acc_cnt !== m_acc || rej_cnt !== m_rej) begin
         failures++; $display("FAIL lfsr_run_final: got asg=%h acc=%0d rej=%0d expected %h/%0d/%0d",
                              cur_asg, acc_cnt, rej_cnt, m_pack(), m_acc, m_rej);
      end
   endtask

   task automatic test_reset_mid();
      int n, pulses;
      n = 0;
      @(negedge clk);
      while (!prop_ready && n < 20) begin @(negedge clk); n++; end
      prop_valid = 1'b1;
      prop_idx   = 3'd0;
      prop_val   = 8'h42;
      prop_thr   = 16'hFFFF;
      @(posedge clk);
      #1;
      prop_valid = 1'b0;
      checks++;
      if (dut_state !== 2'd1) begin
         failures++; $display("FAIL reset_mid_in_decide: got state=%0d expected 1", dut_state);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (prop_ready !== 1'b0 || dut_state !== 2'd0 || cur_asg !== 32'h0 || acc_cnt !== 8'h0 || rej_cnt !== 8'h0) begin
         failures++; $display("FAIL reset_mid_state: got rdy=%b st=%0d asg=%h acc=%0d rej=%0d expected 0/0/0/0/0",
                              prop_ready, dut_state, cur_asg, acc_cnt, rej_cnt);
      end
      pulses = 0;
      repeat (2) begin @(posedge clk); #1; if (commit_valid) pulses++; end
      @(negedge clk);
      rst_n = 1'b1;
      m_reset();
      repeat (4) begin @(posedge clk); #1; if (commit_valid) pulses++; end
      checks++;
      if (pulses != 0 || cur_asg !== 32'h0) begin
         failures++; $display("FAIL reset_mid_no_pulse: got pulses=%0d asg=%h expected 0/00000000", pulses, cur_asg);
      end
   endtask

   task automatic test_ignored_in_decide();
      bit to, e, p, l, a, r, ea, er;
      logic [31:0] asg;
      logic [7:0] ac, rc;
      // init/seed held through DECIDE and WRITE must have no effect.
      do_propose(3'd0, 8'h11, 16'hFFFF, 0, 16'h0, 1, to, e, p, l, a, r, asg, ac, rc);
      m_commit(3'd0, 8'h11, 16'hFFFF, ea, er);
      checks++;
      if (to || !p || a !== 1'b1 || cur_asg !== 32'h00000011) begin
         failures++; $display("FAIL ignore_init: got acc=%b asg=%h expected 1/00000011", a, cur_asg);
      end
      // LFSR E270 -> 7138 only if the seed load was ignored.
      do_propose(3'd1, 8'h22, 16'h7139, 0, 16'h0, 0, to, e, p, l, a, r, asg, ac, rc);
      m_commit(3'd1, 8'h22, 16'h7139, ea, er);
      checks++;
      if (to || !p || a !== 1'b1 || asg !== 32'h00002211) begin
         failures++; $display("FAIL ignore_seed: got acc=%b asg=%h expected 1/00002211", a, asg);
      end
      // 7138 -> 389C; threshold equal to the sample rejects.
      do_propose(3'd2, 8'h33, 16'h389C, 0, 16'h0, 0, to, e, p, l, a, r, asg, ac, rc);
      m_commit(3'd2, 8'h33, 16'h389C, ea, er);
      checks++;
      if (to || !p || a !== 1'b0 || asg !== 32'h00002211 || ac !== 8'd2 || rc !== 8'd1) begin
         failures++; $display("FAIL lfsr_third_step: got acc=%b asg=%h accs=%0d rej=%0d expected 0/00002211/2/1", a, asg, ac, rc);
      end
   endtask

   task automatic test_saturation();
      bit to, e, p, l, a, r, ea, er;
      logic [31:0] asg;
      logic [7:0] ac, rc;
      int bad;
      bad = 0;
      for (int i = 0; i < 260; i++) begin
         do_propose(3'(i % 4), 8'(i), 16'hFFFF, 0, 16'h0, 0, to, e, p, l, a, r, asg, ac, rc);
         m_commit(3'(i % 4), 8'(i), 16'hFFFF, ea, er);
         if (to || !p || a !== 1'b1) bad++;
      end
      checks++;
      if (bad != 0 || acc_cnt !== 8'hFF) begin
         failures++; $display("FAIL accept_saturate: got acc=%h bad=%0d expected FF/0", acc_cnt, bad);
      end
      for (int i = 0; i < 260; i++) begin
         do_propose(3'(i % 4), 8'(i), 16'h0000, 0, 16'h0, 0, to, e, p, l, a, r, asg, ac, rc);
         m_commit(3'(i % 4), 8'(i), 16'h0000, ea, er);
      end
      checks++;
      if (rej_cnt !== 8'hFF || acc_cnt !== 8'hFF || cur_asg !== m_pack()) begin
         failures++; $display("FAIL reject_saturate: got rej=%h acc=%h asg=%h expected FF/FF/%h", rej_cnt, acc_cnt, cur_asg, m_pack());
      end
   endtask

   // ---------------- sequence / report ----------------
   initial begin
      rst_n      = 1'b0;
      init_valid = 1'b0;
      init_asg   = '0;
      seed_load  = 1'b0;
      seed       = '0;
      prop_valid = 1'b0;
      prop_idx   = '0;
      prop_val   = '0;
      prop_thr   = '0;
      m_reset();
      test_reset();
      test_init_accept();
      test_reject_thr0();
      test_seed();
      test_index_error();
      test_lfsr_run();
      test_reset_mid();
      test_ignored_in_decide();
      test_saturation();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
